star_collect_ctrl: RTL and testbench
====================================

// Module: star_collect_ctrl
// PURPOSE
// - Consumer end of the star touch interface: takes per-star touch pulses from the star objects, latches each star as collected, accumulates score, and runs a power-up (invincibility) timer.
// - Sits in game_calc between the star objects and the character/score display logic; drives powered/blink flags to the character renderer.
// PARAMETERS
// - N_STARS       4    number of star objects feeding touch[]
// - STAR_PTS      10   points added per newly collected star
// - SCORE_W       14   score width; score saturates at 2**SCORE_W-1
// - POWER_FRAMES  300  power-up duration in frame_tick units (>= BLINK_FRAMES+1)
// - BLINK_FRAMES  60   final portion of power-up shown as blinking
// - BLINK_PERIOD  4    frame ticks per blink_vis half-period
// PORTS
// - sys_clk        in   1              system clock
// - RST            in   1              asynchronous reset, active-high
// - touch          in   N_STARS        per-star touch level/pulse, bit i = star i
// - frame_tick     in   1              one-cycle pulse per video frame
// - game_restart   in   1              synchronous clear of collected mask, score, timer
// - score          out  SCORE_W        accumulated points
// - collected      out  N_STARS        sticky mask of stars already collected
// - n_collected    out  $clog2(N_STARS+1)  popcount of collected
// - all_collected  out  1              collected == all ones
// - powered        out  1              state != IDLE
// - blink_vis      out  1              character visibility during power-up
// BEHAVIOUR
// - Reset (RST=1, async): score=0, collected=0, n_collected=0, all_collected=0, powered=0, blink_vis=1, FSM=IDLE, timer=0, touch history=0.
// - Touch qualify: new_i = touch[i] & ~touch_d[i] & ~collected[i]; touch_d registered each cycle. Held-high touch counts once; already-collected stars ignored.
// - Latency: touch rising edge at cycle N -> collected/score/powered updated at edge N+1 (one register stage after touch_d compare).
// - Simultaneous touches: all new bits in one cycle collected together; score += popcount(new)*STAR_PTS in that cycle.
// - Score arithmetic: computed at SCORE_W+3 bits, clamped to 2**SCORE_W-1; never wraps.
// - FSM states IDLE, POWERED, BLINK:
//   IDLE    -> POWERED on any new bit; timer <= POWER_FRAMES.
//   POWERED -> timer decrements on frame_tick; -> BLINK when timer reaches BLINK_FRAMES.
//   BLINK   -> timer decrements on frame_tick; -> IDLE when timer reaches 0.
//   any new bit in POWERED/BLINK: timer reloads POWER_FRAMES, state -> POWERED (retrigger), same cycle.
// - New bit and frame_tick same cycle: reload wins, no decrement.
// - blink_vis: 1 in IDLE/POWERED; in BLINK toggles every BLINK_PERIOD frame ticks, starts at 0 on BLINK entry; forced 1 on exit.
// - game_restart: synchronous, highest priority over touch; same outputs as reset except touch_d still samples touch (a held touch does not re-collect after restart until it falls and rises).
// - Timer width $clog2(POWER_FRAMES+1); frame_tick in IDLE has no effect.
// CONFIGURATION
// - STAR_COMBO_EN defined: a star collected while powered=1 adds 2*STAR_PTS; mixed simultaneous touches use the pre-update powered value for all bits.
// - STAR_COMBO_EN undefined: every star adds STAR_PTS regardless of state.
// STRUCTURE
// - Package star_pkg: state enum (ST_IDLE, ST_POWERED, ST_BLINK), default constants STAR_PTS, POWER_FRAMES, BLINK_FRAMES, BLINK_PERIOD, popcount function.
// - One sub-module: star_power_timer (FSM + frame-tick countdown + blink divider); inputs trigger/frame_tick/clear, outputs powered/blink_vis.
// - Top holds edge detect, collected mask, score adder/saturation.
// TESTING
// - Single touch: touch[0] rise, held 5 cycles -> score=10 once, collected=0001, powered=1 next edge.
// - Simultaneous: touch=1010 rise same cycle -> score+=20, n_collected=2 in one cycle.
// - Expiry: one star, 300 frame_ticks -> BLINK after 240 ticks, blink_vis toggles every 4 ticks starting 0, IDLE/powered=0 at tick 300.
// - Retrigger: second star at tick 250 (in BLINK) -> state POWERED, timer=300, blink_vis=1; frame_tick same cycle ignored.
// - Saturation: SCORE_W=5, collect 4 stars -> score=31, not 8.
// - RST asserted mid-BLINK -> all outputs at reset values immediately; game_restart with touch[2] held -> no re-collect until touch[2] toggles.
// - STAR_COMBO_EN: second star while powered -> score 10 then 30; undefined -> 20.

Source files
------------

// File: rtl/star_collect_ctrl_pkg.sv
// star_pkg: shared types and default constants for the star collect block.
//   star_state_e : power-up FSM states (idle, powered, blinking).
//   STAR_PTS, POWER_FRAMES, BLINK_FRAMES, BLINK_PERIOD : default parameters.
//   popcount()   : number of set bits in a 32-bit vector.
package star_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_POWERED = 2'd1,
    ST_BLINK   = 2'd2
  } star_state_e;

  localparam int STAR_PTS     = 10;
  localparam int POWER_FRAMES = 300;
  localparam int BLINK_FRAMES = 60;
  localparam int BLINK_PERIOD = 4;

  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 32'd0;
    for (int i = 0; i < 32; i++) begin
      n = n + 32'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/star_collect_ctrl_if.sv
// star_collect_if: bundle between the star objects / game logic and the
// star collect controller.
//   touch, frame_tick, game_restart : driven by the game side (master)
//   score, collected, n_collected, all_collected, powered, blink_vis :
//     driven by the controller (slave)
interface star_collect_if #(
  parameter int N_STARS = 4,
  parameter int SCORE_W = 14
);
  localparam int CNT_W = $clog2(N_STARS + 1);

  logic [N_STARS-1:0] touch;
  logic               frame_tick;
  logic               game_restart;
  logic [SCORE_W-1:0] score;
  logic [N_STARS-1:0] collected;
  logic [CNT_W-1:0]   n_collected;
  logic               all_collected;
  logic               powered;
  logic               blink_vis;

  modport master (
    output touch, frame_tick, game_restart,
    input  score, collected, n_collected, all_collected, powered, blink_vis
  );

  modport slave (
    input  touch, frame_tick, game_restart,
    output score, collected, n_collected, all_collected, powered, blink_vis
  );
endinterface

// File: rtl/star_collect_ctrl_power_timer.sv
// star_power_timer: power-up FSM with frame-tick countdown and blink divider.
//   clk, rst    : clock, asynchronous active-high reset
//   trigger     : a star was newly collected this cycle (reload timer)
//   frame_tick  : one-cycle pulse per video frame
//   clear       : synchronous clear, beats trigger
//   powered     : power-up active (state not idle)
//   blink_vis   : character visibility, toggles during the final blink window
module star_power_timer #(
  parameter int POWER_FRAMES = star_pkg::POWER_FRAMES,
  parameter int BLINK_FRAMES = star_pkg::BLINK_FRAMES,
  parameter int BLINK_PERIOD = star_pkg::BLINK_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic trigger,
  input  logic frame_tick,
  input  logic clear,
  output logic powered,
  output logic blink_vis
);
  import star_pkg::*;

  localparam int TMR_W = $clog2(POWER_FRAMES + 1);
  localparam int BLK_W = (BLINK_PERIOD > 1) ? $clog2(BLINK_PERIOD) : 1;

  star_state_e      state, state_nxt;
  logic [TMR_W-1:0] timer, timer_nxt;
  logic [BLK_W-1:0] blk_cnt, blk_cnt_nxt;
  logic             vis, vis_nxt;

  // State, countdown, blink divider and visibility registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      timer   <= {TMR_W{1'b0}};
      blk_cnt <= {BLK_W{1'b0}};
      vis     <= 1'b1;
    end else begin
      state   <= state_nxt;
      timer   <= timer_nxt;
      blk_cnt <= blk_cnt_nxt;
      vis     <= vis_nxt;
    end
  end

  // Next-state logic: clear > trigger (reload) > frame_tick countdown.
  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    blk_cnt_nxt = blk_cnt;
    vis_nxt     = vis;
    if (clear) begin
      state_nxt   = ST_IDLE;
      timer_nxt   = {TMR_W{1'b0}};
      blk_cnt_nxt = {BLK_W{1'b0}};
      vis_nxt     = 1'b1;
    end else if (trigger) begin
      // Retrigger from any state restarts the full power-up, visible.
      state_nxt   = ST_POWERED;
      timer_nxt   = TMR_W'(POWER_FRAMES);
      blk_cnt_nxt = {BLK_W{1'b0}};
      vis_nxt     = 1'b1;
    end else if (frame_tick) begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_IDLE;
        end
        ST_POWERED: begin
          timer_nxt = timer - TMR_W'(1);
          if (timer_nxt == TMR_W'(BLINK_FRAMES)) begin
            // Blink window opens hidden, divider starts fresh.
            state_nxt   = ST_BLINK;
            blk_cnt_nxt = {BLK_W{1'b0}};
            vis_nxt     = 1'b0;
          end else begin
            state_nxt = ST_POWERED;
          end
        end
        ST_BLINK: begin
          timer_nxt = timer - TMR_W'(1);
          if (timer_nxt == {TMR_W{1'b0}}) begin
            state_nxt   = ST_IDLE;
            blk_cnt_nxt = {BLK_W{1'b0}};
            vis_nxt     = 1'b1;
          end else if (blk_cnt == BLK_W'(BLINK_PERIOD - 1)) begin
            blk_cnt_nxt = {BLK_W{1'b0}};
            vis_nxt     = ~vis;
          end else begin
            blk_cnt_nxt = blk_cnt + BLK_W'(1);
          end
        end
        default: begin
          state_nxt   = ST_IDLE;
          timer_nxt   = {TMR_W{1'b0}};
          blk_cnt_nxt = {BLK_W{1'b0}};
          vis_nxt     = 1'b1;
        end
      endcase
    end else begin
      state_nxt = state;
    end
  end

  assign powered   = (state != ST_IDLE);
  assign blink_vis = vis;

endmodule

// File: rtl/star_collect_ctrl.sv
// star_collect_ctrl: latches touched stars as collected, accumulates a
// saturating score and drives the power-up timer.
//   sys_clk : system clock
//   RST     : asynchronous active-high reset
//   bus     : star_collect_if.slave (touch/frame_tick/game_restart in;
//             score/collected/n_collected/all_collected/powered/blink_vis out)
// Build option: STAR_COMBO_EN -- stars collected while powered score double.
module star_collect_ctrl #(
  parameter int N_STARS      = 4,
  parameter int STAR_PTS     = star_pkg::STAR_PTS,
  parameter int SCORE_W      = 14,
  parameter int POWER_FRAMES = star_pkg::POWER_FRAMES,
  parameter int BLINK_FRAMES = star_pkg::BLINK_FRAMES,
  parameter int BLINK_PERIOD = star_pkg::BLINK_PERIOD
) (
  input logic           sys_clk,
  input logic           RST,
  star_collect_if.slave bus
);
  import star_pkg::*;

  localparam int CNT_W = $clog2(N_STARS + 1);
  localparam int SUM_W = SCORE_W + 3;
  localparam logic [SUM_W-1:0] SCORE_MAX = SUM_W'((64'd1 << SCORE_W) - 64'd1);

  logic [N_STARS-1:0] touch_d, collected_q, new_bits, collected_nxt;
  logic [SCORE_W-1:0] score_q, score_sat;
  logic [CNT_W-1:0]   n_collected_q;
  logic               all_q;
  logic [SUM_W-1:0]   pts_each, gained, sum;
  logic               trigger, powered;

  // Edge-qualified new stars and the saturated score they produce.
  always_comb begin
    new_bits      = bus.touch & ~touch_d & ~collected_q;
    trigger       = |new_bits;
    collected_nxt = collected_q | new_bits;
`ifdef STAR_COMBO_EN
    // Pre-update powered applies to every bit collected this cycle.
    if (powered) begin
      pts_each = SUM_W'(2 * STAR_PTS);
    end else begin
      pts_each = SUM_W'(STAR_PTS);
    end
`else
    pts_each = SUM_W'(STAR_PTS);
`endif
    gained = SUM_W'(popcount(32'(new_bits))) * pts_each;
    sum    = {3'b000, score_q} + gained;
    if (sum > SCORE_MAX) begin
      score_sat = SCORE_MAX[SCORE_W-1:0];
    end else begin
      score_sat = sum[SCORE_W-1:0];
    end
  end

  // Touch history always samples; restart clears mask and score.
  always_ff @(posedge sys_clk or posedge RST) begin
    if (RST) begin
      touch_d       <= {N_STARS{1'b0}};
      collected_q   <= {N_STARS{1'b0}};
      score_q       <= {SCORE_W{1'b0}};
      n_collected_q <= {CNT_W{1'b0}};
      all_q         <= 1'b0;
    end else begin
      touch_d <= bus.touch;
      if (bus.game_restart) begin
        collected_q   <= {N_STARS{1'b0}};
        score_q       <= {SCORE_W{1'b0}};
        n_collected_q <= {CNT_W{1'b0}};
        all_q         <= 1'b0;
      end else begin
        collected_q   <= collected_nxt;
        score_q       <= score_sat;
        n_collected_q <= CNT_W'(popcount(32'(collected_nxt)));
        all_q         <= &collected_nxt;
      end
    end
  end

  star_power_timer #(
    .POWER_FRAMES(POWER_FRAMES),
    .BLINK_FRAMES(BLINK_FRAMES),
    .BLINK_PERIOD(BLINK_PERIOD)
  ) u_timer (
    .clk       (sys_clk),
    .rst       (RST),
    .trigger   (trigger),
    .frame_tick(bus.frame_tick),
    .clear     (bus.game_restart),
    .powered   (powered),
    .blink_vis (bus.blink_vis)
  );

  assign bus.score         = score_q;
  assign bus.collected     = collected_q;
  assign bus.n_collected   = n_collected_q;
  assign bus.all_collected = all_q;
  assign bus.powered       = powered;

endmodule

// File: tb/tb_star_collect_ctrl.sv
// tb_star_collect_ctrl: directed stimulus with a frame-count model of the
// star collector; a 14-bit and a 5-bit score instance run side by side.
module tb_star_collect_ctrl;

`ifdef STAR_COMBO_EN
  localparam int COMBO = 1;
`else
  localparam int COMBO = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   check_en = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  star_collect_if #(.N_STARS(4), .SCORE_W(14)) if_m ();
  star_collect_if #(.N_STARS(4), .SCORE_W(5))  if_s ();

  assign if_s.touch        = if_m.touch;
  assign if_s.frame_tick   = if_m.frame_tick;
  assign if_s.game_restart = if_m.game_restart;

  star_collect_ctrl #(.SCORE_W(14)) dut   (.sys_clk(clk), .RST(rst), .bus(if_m));
  star_collect_ctrl #(.SCORE_W(5))  dut_s (.sys_clk(clk), .RST(rst), .bus(if_s));

  // Model: frames of power-up left, collected mask, two saturating scores.
  logic [3:0] m_prev = 4'd0;
  logic [3:0] m_coll = 4'd0;
  int         m_s14  = 0;
  int         m_s5   = 0;
  int         m_left = 0;
  logic [3:0] m_new;
  int         m_gain;

  assign m_new  = if_m.touch & ~m_prev & ~m_coll;
  assign m_gain = $countones(m_new) * ((COMBO == 1 && m_left > 0) ? 20 : 10);

  function automatic int exp_vis(input int left);
    if (left > 0 && left <= 60) return (((60 - left) / 4) % 2 == 1) ? 1 : 0;
    return 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_prev <= 4'd0; m_coll <= 4'd0; m_s14 <= 0; m_s5 <= 0; m_left <= 0;
    end else begin
      m_prev <= if_m.touch;
      if (if_m.game_restart) begin
        m_coll <= 4'd0; m_s14 <= 0; m_s5 <= 0; m_left <= 0;
      end else begin
        m_coll <= m_coll | m_new;
        m_s14  <= (m_s14 + m_gain > 16383) ? 16383 : m_s14 + m_gain;
        m_s5   <= (m_s5 + m_gain > 31) ? 31 : m_s5 + m_gain;
        if (m_new != 4'd0) m_left <= 300;
        else if (if_m.frame_tick && m_left > 0) m_left <= m_left - 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the clock edge.
  always @(negedge clk) begin
    if (check_en) begin
      chk("m_score",     int'(if_m.score),         m_s14);
      chk("m_collected", int'(if_m.collected),     int'(m_coll));
      chk("m_n_coll",    int'(if_m.n_collected),   $countones(m_coll));
      chk("m_all",       int'(if_m.all_collected), (m_coll == 4'hF) ? 1 : 0);
      chk("m_powered",   int'(if_m.powered),       (m_left > 0) ? 1 : 0);
      chk("m_blink_vis", int'(if_m.blink_vis),     exp_vis(m_left));
      chk("m_score5",    int'(if_s.score),         m_s5);
    end
  end

  task automatic step(input logic [3:0] t, input logic ft, input logic gr);
    @(negedge clk);
    if_m.touch = t; if_m.frame_tick = ft; if_m.game_restart = gr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    if_m.touch = 4'd0; if_m.frame_tick = 1'b0; if_m.game_restart = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_en = 1'b1;
    #1;
    chk("rst_score", int'(if_m.score), 0);
    chk("rst_powered", int'(if_m.powered), 0);
    chk("rst_vis", int'(if_m.blink_vis), 1);

    // Single touch held high counts once.
    step(4'b0001, 1'b0, 1'b0);
    chk("single_score", int'(if_m.score), 10);
    chk("single_coll", int'(if_m.collected), 1);
    chk("single_pow", int'(if_m.powered), 1);
    repeat (5) step(4'b0001, 1'b0, 1'b0);
    chk("held_score", int'(if_m.score), 10);
    step(4'b0000, 1'b0, 1'b0);

    // Expiry: blink window after 240 ticks, idle after 300.
    for (int i = 1; i <= 300; i++) begin
      step(4'b0000, 1'b1, 1'b0);
      if (i == 239) chk("pre_blink_vis", int'(if_m.blink_vis), 1);
      if (i == 240) chk("blink_entry_vis", int'(if_m.blink_vis), 0);
      if (i == 244) chk("blink_toggle_vis", int'(if_m.blink_vis), 1);
      if (i == 299) chk("last_powered", int'(if_m.powered), 1);
      if (i == 300) chk("expired_pow", int'(if_m.powered), 0);
      if (i == 300) chk("expired_vis", int'(if_m.blink_vis), 1);
    end

    // Restart then two stars touched together.
    step(4'b0000, 1'b0, 1'b1);
    chk("restart_score", int'(if_m.score), 0);
    step(4'b1010, 1'b0, 1'b0);
    chk("simul_score", int'(if_m.score), 20);
    chk("simul_n", int'(if_m.n_collected), 2);
    step(4'b0000, 1'b0, 1'b0);

    // Retrigger inside the blink window with a coincident frame tick.
    for (int i = 1; i <= 250; i++) begin
      step((i == 250) ? 4'b0001 : 4'b0000, 1'b1, 1'b0);
      if (i == 249) chk("blink_vis_249", int'(if_m.blink_vis), 0);
    end
    chk("retrig_pow", int'(if_m.powered), 1);
    chk("retrig_vis", int'(if_m.blink_vis), 1);
    chk("retrig_score", int'(if_m.score), (COMBO == 1) ? 40 : 30);
    for (int j = 1; j <= 245; j++) begin
      step(4'b0000, 1'b1, 1'b0);
      if (j == 239) chk("reload_vis_239", int'(if_m.blink_vis), 1);
      if (j == 240) chk("reload_vis_240", int'(if_m.blink_vis), 0);
    end

    // Asynchronous reset in the middle of blinking.
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_score", int'(if_m.score), 0);
    chk("arst_coll", int'(if_m.collected), 0);
    chk("arst_all", int'(if_m.all_collected), 0);
    chk("arst_pow", int'(if_m.powered), 0);
    chk("arst_vis", int'(if_m.blink_vis), 1);
    @(negedge clk);
    if_m.frame_tick = 1'b0;
    #2 rst = 1'b0;

    // Saturation on the 5-bit instance.
    step(4'b0001, 1'b0, 1'b0);
    step(4'b0010, 1'b0, 1'b0);
    chk("combo_second", int'(if_m.score), (COMBO == 1) ? 30 : 20);
    step(4'b0100, 1'b0, 1'b0);
    chk("sat5_third", int'(if_s.score), (COMBO == 1) ? 31 : 30);
    step(4'b1000, 1'b0, 1'b0);
    chk("sat5_final", int'(if_s.score), 31);
    chk("sat14_final", int'(if_m.score), (COMBO == 1) ? 70 : 40);
    chk("all_coll", int'(if_m.all_collected), 1);

    // Restart with touch[2] held: no re-collect until it toggles.
    step(4'b0100, 1'b0, 1'b1);
    chk("rs_coll", int'(if_m.collected), 0);
    repeat (3) step(4'b0100, 1'b1, 1'b0);
    chk("rs_held_coll", int'(if_m.collected), 0);
    chk("rs_idle_pow", int'(if_m.powered), 0);
    step(4'b0000, 1'b0, 1'b0);
    step(4'b0100, 1'b0, 1'b0);
    chk("rs_recoll", int'(if_m.collected), 4);
    chk("rs_score", int'(if_m.score), 10);
    step(4'b0101, 1'b1, 1'b0);
    chk("rs_combo", int'(if_m.score), (COMBO == 1) ? 30 : 20);
    repeat (4) step(4'b0000, 1'b1, 1'b0);

    @(negedge clk);
    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
